// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counter block.
package counter_pkg;

  localparam int unsigned COUNTER_DEFAULT_WIDTH = 4;

  // Largest value representable in `width` bits; also the default terminal value.
  function automatic int unsigned counter_max(input int unsigned width);
    if (width >= 32) begin
      return 32'hFFFF_FFFF;
    end
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/counter_next.sv
// Combinational next-state logic for counter: increment with wrap at MAX_COUNT.
module counter_next
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = COUNTER_DEFAULT_WIDTH,
  parameter int unsigned MAX_COUNT = counter_max(WIDTH)
) (
  input  logic [WIDTH-1:0] i_count,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_next_count,
  output logic             o_wrap
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_COUNT);

  logic w_at_or_past_max;

  // Any out-of-range value also loads 0, so forced bad state self-recovers.
  assign w_at_or_past_max = (i_count >= MaxVal);

  always_comb begin
    o_next_count = i_count;
    if (i_en) begin
      if (w_at_or_past_max) begin
        o_next_count = '0;
      end else begin
        o_next_count = i_count + WIDTH'(1);
      end
    end
  end

  assign o_wrap = i_en & (i_count == MaxVal);

endmodule

// File: rtl/counter.sv
// Enable-gated modulo up-counter; state register and reset only.
// Optional terminal-count output tc is enabled by defining COUNTER_TC_EN.
module counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = COUNTER_DEFAULT_WIDTH,
  parameter int unsigned MAX_COUNT = counter_max(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
`ifdef COUNTER_TC_EN
  output logic             tc,
`endif
  output logic [WIDTH-1:0] count
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("counter: WIDTH must be in 1..32");
  end
  if (MAX_COUNT == 0 || MAX_COUNT > counter_max(WIDTH)) begin : g_bad_max
    $error("counter: MAX_COUNT must satisfy 0 < MAX_COUNT <= 2**WIDTH-1");
  end

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next_count;
  logic             w_wrap;

  counter_next #(
    .WIDTH     (WIDTH),
    .MAX_COUNT (MAX_COUNT)
  ) u_next (
    .i_count      (r_count),
    .i_en         (en),
    .o_next_count (w_next_count),
    .o_wrap       (w_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_next_count;
    end
  end

  assign count = r_count;

`ifdef COUNTER_TC_EN
  // Count is 0 in reset and MAX_COUNT > 0, so tc is naturally low there.
  assign tc = w_wrap;
`else
  logic w_unused_wrap;
  assign w_unused_wrap = w_wrap;
`endif

  a_en_known : assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(en))
    else $error("counter: en is unknown at clock edge");

endmodule

// File: tb/tb_counter.sv
// Directed self-checking bench for counter (default and MAX_COUNT=9 instances).
module tb_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       en9;
  logic [3:0] count;
  logic [3:0] count9;
`ifdef COUNTER_TC_EN
  logic       tc;
  logic       tc9;
`endif

  int total;
  int bad;

  counter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
`ifdef COUNTER_TC_EN
    .tc    (tc),
`endif
    .count (count)
  );

  counter #(
    .WIDTH     (4),
    .MAX_COUNT (9)
  ) dut9 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en9),
`ifdef COUNTER_TC_EN
    .tc    (tc9),
`endif
    .count (count9)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (count !== 4'd0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d count=%0d expected=0", i, count);
      end
`ifdef COUNTER_TC_EN
      total++;
      if (tc !== 1'b0) begin
        bad++;
        $display("FAIL reset_tc cyc=%0d tc=%b expected=0", i, tc);
      end
`endif
    end
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    total++;
    if (count !== 4'd7) begin
      bad++;
      $display("FAIL reset_pre_async count=%0d expected=7", count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (count !== 4'd0) begin
      bad++;
      $display("FAIL reset_async count=%0d expected=0", count);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_count();
    logic [3:0] exp;
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      exp = 4'((i + 1) % 16);
      total++;
      if (count !== exp) begin
        bad++;
        $display("FAIL count_seq step=%0d count=%0d expected=%0d", i, count, exp);
      end
    end
  endtask

  task automatic test_hold();
    en = 1'b1;
    tick();
    total++;
    if (count !== 4'd5) begin
      bad++;
      $display("FAIL hold_setup count=%0d expected=5", count);
    end
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (count !== 4'd5) begin
        bad++;
        $display("FAIL hold_en0 cyc=%0d count=%0d expected=5", i, count);
      end
    end
    en = 1'b1;
    tick();
    total++;
    if (count !== 4'd6) begin
      bad++;
      $display("FAIL hold_resume count=%0d expected=6", count);
    end
  endtask

  task automatic test_alternate();
    logic [4:0] pat;
    logic [3:0] exp [5];
    pat = 5'b10101;
    exp = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd3};
    en = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      en = pat[4-i];
      tick();
      total++;
      if (count !== exp[i]) begin
        bad++;
        $display("FAIL alt_en step=%0d count=%0d expected=%0d", i, count, exp[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_non_pow2();
    logic [3:0] exp;
    en  = 1'b0;
    en9 = 1'b0;
    do_reset();
    en9 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp = 4'((i + 1) % 10);
      total++;
      if (count9 !== exp) begin
        bad++;
        $display("FAIL max9_seq step=%0d count=%0d expected=%0d", i, count9, exp);
      end
    end
    en9 = 1'b0;
  endtask

`ifdef COUNTER_TC_EN
  task automatic test_tc();
    en = 1'b0;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    total++;
    if (count !== 4'd14 || tc !== 1'b0) begin
      bad++;
      $display("FAIL tc_at14 count=%0d tc=%b expected count=14 tc=0", count, tc);
    end
    tick();
    total++;
    if (count !== 4'd15 || tc !== 1'b1) begin
      bad++;
      $display("FAIL tc_at15_en1 count=%0d tc=%b expected count=15 tc=1", count, tc);
    end
    en = 1'b0;
    #1;
    total++;
    if (tc !== 1'b0) begin
      bad++;
      $display("FAIL tc_at15_en0 tc=%b expected=0", tc);
    end
    tick();
    total++;
    if (count !== 4'd15 || tc !== 1'b0) begin
      bad++;
      $display("FAIL tc_hold count=%0d tc=%b expected count=15 tc=0", count, tc);
    end
    en = 1'b1;
    #1;
    total++;
    if (tc !== 1'b1) begin
      bad++;
      $display("FAIL tc_reen tc=%b expected=1", tc);
    end
    tick();
    total++;
    if (count !== 4'd0 || tc !== 1'b0) begin
      bad++;
      $display("FAIL tc_wrap count=%0d tc=%b expected count=0 tc=0", count, tc);
    end
    en = 1'b0;
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    en9   = 1'b0;
    #1;
    test_reset();
    test_count();
    test_hold();
    test_alternate();
    test_non_pow2();
`ifdef COUNTER_TC_EN
    test_tc();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
